// File: rtl/chroni_mem_arbiter_pkg.sv
// Shared definitions for the chroni memory-port arbiter: FSM state encoding
// and requester identifiers.
package chroni_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_GRANT_VID = 2'd1,
        ARB_GRANT_CPU = 2'd2,
        ARB_RESP      = 2'd3
    } arb_state_t;

    localparam logic REQ_VID = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/chroni_mem_arbiter.sv
// chroni memory-port arbiter: shares one VRAM read/write port between the
// real-time video fetch engine (high priority) and the CPU path (low priority,
// protected against starvation by a bounded video streak). One transfer per
// req/ack handshake, with an optional memory-ack timeout.
module chroni_mem_arbiter
    import chroni_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter int PAGE_W         = 8,
    parameter int DATA_W         = 8,
    parameter int MAX_VID_STREAK = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic [PAGE_W-1:0] vid_page,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [PAGE_W-1:0] cpu_page,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PAGE_W-1:0] mem_page,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              err_clr,
    output logic              timeout_err
);

    localparam int STREAK_W = (MAX_VID_STREAK < 1) ? 1 : $clog2(MAX_VID_STREAK + 1);
    localparam int TO_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);
    // Abort happens on the edge where the count would reach TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic TO_EN = (TIMEOUT != 0);

    arb_state_t          state_r, state_nxt_s;
    logic                grant_vid_s, grant_cpu_s, done_s, abort_s;
    logic                owner_s;
    logic [STREAK_W-1:0] streak_r, streak_nxt_s;
    logic [TO_W-1:0]     to_cnt_r, to_cnt_nxt_s;
    logic [DATA_W-1:0]   resp_data_s;

    logic                mem_req_r, mem_req_nxt_s;
    logic                mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
    logic [PAGE_W-1:0]   mem_page_r, mem_page_nxt_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
    logic                vid_ack_r, vid_ack_nxt_s;
    logic                cpu_ack_r, cpu_ack_nxt_s;
    logic [DATA_W-1:0]   vid_rdata_r, vid_rdata_nxt_s;
    logic [DATA_W-1:0]   cpu_rdata_r, cpu_rdata_nxt_s;
    logic                timeout_err_r, timeout_err_nxt_s;

    // State register.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout in GRANT_x.
    always_comb begin
        state_nxt_s = state_r;
        grant_vid_s = 1'b0;
        grant_cpu_s = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (cpu_req && (!vid_req || (streak_r == STREAK_MAX))) begin
                    grant_cpu_s = 1'b1;
                    state_nxt_s = ARB_GRANT_CPU;
                end else if (vid_req) begin
                    grant_vid_s = 1'b1;
                    state_nxt_s = ARB_GRANT_VID;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GRANT_VID, ARB_GRANT_CPU: begin
                // A late ack in the timeout cycle still counts as a completion.
                if (mem_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ARB_RESP;
                end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ARB_RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ARB_RESP: begin
                state_nxt_s = ARB_IDLE;
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Output logic: next values of every registered output and counter.
    always_comb begin
        mem_req_nxt_s     = mem_req_r;
        mem_we_nxt_s      = mem_we_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_page_nxt_s    = mem_page_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        vid_ack_nxt_s     = 1'b0;
        cpu_ack_nxt_s     = 1'b0;
        vid_rdata_nxt_s   = vid_rdata_r;
        cpu_rdata_nxt_s   = cpu_rdata_r;
        streak_nxt_s      = streak_r;
        to_cnt_nxt_s      = to_cnt_r;
        owner_s           = (state_r == ARB_GRANT_CPU) ? REQ_CPU : REQ_VID;
        resp_data_s       = {DATA_W{1'b0}};
        if (abort_s) begin
            resp_data_s = {DATA_W{1'b1}};
        end else if (mem_we_r) begin
            resp_data_s = {DATA_W{1'b0}};
        end else begin
            resp_data_s = mem_rdata;
        end

        if (grant_cpu_s) begin
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = cpu_we;
            mem_addr_nxt_s  = cpu_addr;
            mem_page_nxt_s  = cpu_page;
            mem_wdata_nxt_s = cpu_wdata;
            streak_nxt_s    = {STREAK_W{1'b0}};
            to_cnt_nxt_s    = {TO_W{1'b0}};
        end else if (grant_vid_s) begin
            mem_req_nxt_s   = 1'b1;
            mem_we_nxt_s    = 1'b0;
            mem_addr_nxt_s  = vid_addr;
            mem_page_nxt_s  = vid_page;
            mem_wdata_nxt_s = {DATA_W{1'b0}};
            to_cnt_nxt_s    = {TO_W{1'b0}};
            if (!cpu_req) begin
                streak_nxt_s = {STREAK_W{1'b0}};
            end else if (streak_r != STREAK_MAX) begin
                streak_nxt_s = streak_r + STREAK_W'(1);
            end else begin
                streak_nxt_s = streak_r;
            end
        end else if (done_s || abort_s) begin
            mem_req_nxt_s = 1'b0;
            mem_we_nxt_s  = 1'b0;
            if (owner_s == REQ_CPU) begin
                cpu_ack_nxt_s   = 1'b1;
                cpu_rdata_nxt_s = resp_data_s;
            end else begin
                vid_ack_nxt_s   = 1'b1;
                vid_rdata_nxt_s = resp_data_s;
            end
        end else if ((state_r == ARB_GRANT_VID) || (state_r == ARB_GRANT_CPU)) begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_nxt_s = to_cnt_r;
        end

        // A new timeout overrides a simultaneous clear.
        if (abort_s) begin
            timeout_err_nxt_s = 1'b1;
        end else if (err_clr) begin
            timeout_err_nxt_s = 1'b0;
        end else begin
            timeout_err_nxt_s = timeout_err_r;
        end
    end

    // Output and counter registers; reset drops any in-flight transfer.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_page_r    <= {PAGE_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            vid_ack_r     <= 1'b0;
            cpu_ack_r     <= 1'b0;
            vid_rdata_r   <= {DATA_W{1'b0}};
            cpu_rdata_r   <= {DATA_W{1'b0}};
            streak_r      <= {STREAK_W{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            mem_req_r     <= mem_req_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_page_r    <= mem_page_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            vid_ack_r     <= vid_ack_nxt_s;
            cpu_ack_r     <= cpu_ack_nxt_s;
            vid_rdata_r   <= vid_rdata_nxt_s;
            cpu_rdata_r   <= cpu_rdata_nxt_s;
            streak_r      <= streak_nxt_s;
            to_cnt_r      <= to_cnt_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_page    = mem_page_r;
    assign mem_wdata   = mem_wdata_r;
    assign vid_ack     = vid_ack_r;
    assign cpu_ack     = cpu_ack_r;
    assign vid_rdata   = vid_rdata_r;
    assign cpu_rdata   = cpu_rdata_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_chroni_mem_arbiter.sv
// Directed self-checking bench for chroni_mem_arbiter (MAX_VID_STREAK=4, TIMEOUT=8).
module tb_chroni_mem_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_page;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_page;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_page;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        err_clr;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    chroni_mem_arbiter #(
        .ADDR_W(13), .PAGE_W(8), .DATA_W(8), .MAX_VID_STREAK(4), .TIMEOUT(8)
    ) dut (
        .vga_clk(vga_clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_page(vid_page),
        .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_page(cpu_page),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_page(mem_page),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; vid_req = 1'b0; vid_addr = 13'h0; vid_page = 8'h0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0; cpu_page = 8'h0; cpu_wdata = 8'h0;
        mem_ack = 1'b0; mem_rdata = 8'h0; err_clr = 1'b0;
        tick(); tick();
        checks++;
        if ({mem_req, mem_we, vid_ack, cpu_ack, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, vid_ack, cpu_ack, timeout_err});
        end
        checks++;
        if ({mem_addr, mem_page, mem_wdata, vid_rdata, cpu_rdata} !== 45'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_page, mem_wdata, vid_rdata, cpu_rdata});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_vid_read();
        vid_req = 1'b1; vid_addr = 13'h401; vid_page = 8'h00;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_page} !== {1'b1, 1'b0, 13'h401, 8'h00}) begin
            errors++; $display("FAIL vid_grant: got req=%b we=%b addr=%h page=%h expected 1 0 401 00", mem_req, mem_we, mem_addr, mem_page);
        end
        tick(); tick();
        checks++;
        if (mem_req !== 1'b1 || vid_ack !== 1'b0) begin
            errors++; $display("FAIL vid_hold: got req=%b ack=%b expected 1 0", mem_req, vid_ack);
        end
        mem_ack = 1'b1; mem_rdata = 8'h41;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        checks++;
        if ({vid_ack, vid_rdata, cpu_ack, mem_req} !== {1'b1, 8'h41, 1'b0, 1'b0}) begin
            errors++; $display("FAIL vid_ack: got ack=%b data=%h cpu_ack=%b req=%b expected 1 41 0 0", vid_ack, vid_rdata, cpu_ack, mem_req);
        end
        vid_req = 1'b0;
        tick();
        checks++;
        if (vid_ack !== 1'b0) begin
            errors++; $display("FAIL vid_ack_pulse: got %b expected 0", vid_ack);
        end
    endtask

    task automatic test_streak();
        logic exp_cpu;
        int   wait_cnt;
        vid_req = 1'b1; vid_addr = 13'h100; vid_page = 8'h01;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h200; cpu_page = 8'h03;
        for (int g = 0; g < 10; g++) begin
            exp_cpu = ((g % 5) == 4);
            wait_cnt = 0;
            while (mem_req !== 1'b1 && wait_cnt < 6) begin
                tick();
                wait_cnt++;
            end
            checks++;
            if (mem_req !== 1'b1) begin
                errors++; $display("FAIL streak_wait: grant %0d got no mem_req expected 1", g);
            end
            checks++;
            if (mem_addr !== (exp_cpu ? 13'h200 : 13'h100)) begin
                errors++; $display("FAIL streak_order: grant %0d got addr %h expected %h", g, mem_addr, exp_cpu ? 13'h200 : 13'h100);
            end
            tick();
            mem_ack = 1'b1; mem_rdata = 8'h80 + 8'(g);
            tick();
            mem_ack = 1'b0;
            checks++;
            if ({vid_ack, cpu_ack} !== (exp_cpu ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL streak_ack: grant %0d got vid=%b cpu=%b expected cpu=%b", g, vid_ack, cpu_ack, exp_cpu);
            end
            checks++;
            if ((exp_cpu ? cpu_rdata : vid_rdata) !== 8'h80 + 8'(g)) begin
                errors++; $display("FAIL streak_data: grant %0d got %h expected %h", g, exp_cpu ? cpu_rdata : vid_rdata, 8'h80 + 8'(g));
            end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h010; cpu_page = 8'h02; cpu_wdata = 8'h5A;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_page, mem_wdata} !== {1'b1, 1'b1, 13'h010, 8'h02, 8'h5A}) begin
                errors++; $display("FAIL cpu_wr_hold: cycle %0d got req=%b we=%b addr=%h page=%h wdata=%h expected 1 1 010 02 5a", k, mem_req, mem_we, mem_addr, mem_page, mem_wdata);
            end
            if (k < 2) tick();
        end
        mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        checks++;
        if ({cpu_ack, cpu_rdata, vid_ack, mem_req} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++; $display("FAIL cpu_wr_ack: got ack=%b data=%h vid_ack=%b req=%b expected 1 00 0 0", cpu_ack, cpu_rdata, vid_ack, mem_req);
        end
        tick();
    endtask

    task automatic test_timeout(input logic clr_held);
        err_clr = clr_held;
        vid_req = 1'b1; vid_addr = 13'h020; vid_page = 8'h00;
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (mem_req !== 1'b1 || vid_ack !== 1'b0) begin
                errors++; $display("FAIL to_hold: cycle %0d got req=%b ack=%b expected 1 0", k, mem_req, vid_ack);
            end
            tick();
        end
        vid_req = 1'b0;
        checks++;
        if ({mem_req, vid_ack, vid_rdata, timeout_err} !== {1'b0, 1'b1, 8'hFF, 1'b1}) begin
            errors++; $display("FAIL to_abort: got req=%b ack=%b data=%h err=%b expected 0 1 ff 1", mem_req, vid_ack, vid_rdata, timeout_err);
        end
        if (!clr_held) begin
            tick();
            checks++;
            if (timeout_err !== 1'b1 || vid_ack !== 1'b0) begin
                errors++; $display("FAIL to_sticky: got err=%b ack=%b expected 1 0", timeout_err, vid_ack);
            end
            err_clr = 1'b1;
        end
        tick();
        err_clr = 1'b0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_clear: got %b expected 0", timeout_err);
        end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        vid_req = 1'b1; vid_addr = 13'h030; vid_page = 8'h05;
        tick();
        for (int k = 0; k < 7; k++) tick();
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0; vid_req = 1'b0;
        checks++;
        if ({vid_ack, vid_rdata, timeout_err, mem_req} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
            errors++; $display("FAIL ack_at_to: got ack=%b data=%h err=%b req=%b expected 1 3c 0 0", vid_ack, vid_rdata, timeout_err, mem_req);
        end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h033; cpu_page = 8'h04;
        tick(); tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got %b expected 1", mem_req);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, cpu_ack} !== {1'b0, 13'h000, 1'b0}) begin
            errors++; $display("FAIL rst_async: got req=%b addr=%h ack=%b expected 0 000 0", mem_req, mem_addr, cpu_ack);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        reset = 1'b0;
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++; $display("FAIL rst_no_ack: got %b expected 0", cpu_ack);
        end
        tick();
        checks++;
        if ({mem_req, mem_addr, mem_page} !== {1'b1, 13'h033, 8'h04}) begin
            errors++; $display("FAIL rst_regrant: got req=%b addr=%h page=%h expected 1 033 04", mem_req, mem_addr, mem_page);
        end
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0; cpu_req = 1'b0;
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 8'hC3}) begin
            errors++; $display("FAIL rst_ack: got ack=%b data=%h expected 1 c3", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vid_read();
        test_streak();
        test_cpu_write();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_ack_at_timeout();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
